// File: rtl/regfile_scan_display.sv
// Scans four regfile entries onto a multiplexed 4-digit seven-segment display.
// Optional REGFILE_SCAN_PAGE_DP_EN lights the digit-3 decimal point when the upper page is shown.
module regfile_scan_display #(
  parameter int DWELL_CYCLES = 100000,
  parameter int CNT_W        = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       page,
  input  logic       blank,
  input  logic [3:0] rd_data,
  output logic [2:0] rd_addr,
  output logic [7:0] segment,
  output logic [3:0] anode
);

  typedef enum logic [1:0] {SETTLE, CAPTURE, SHOW} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           state;
  logic [1:0]       digit;
  logic             page_q;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       seg_q;
  logic             dp;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SETTLE;
      digit   <= 2'd0;
      page_q  <= 1'b0;
      cnt     <= '0;
      rd_addr <= 3'd0;
      seg_q   <= 7'h7F;
    end else begin
      case (state)
        SETTLE:  state <= CAPTURE;
        CAPTURE: begin
          seg_q <= decode(rd_data);
          state <= SHOW;
        end
        SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
            state <= SETTLE;
            // page is only taken at the frame boundary so a frame never mixes pages
            if (digit == 2'd3) begin
              page_q  <= page;
              rd_addr <= {page, 2'd0};
            end else begin
              rd_addr <= {page_q, digit + 2'd1};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

  always_comb begin
    anode = 4'hF;
    if (state == SHOW && !blank) anode[digit] = 1'b0;
  end

`ifdef REGFILE_SCAN_PAGE_DP_EN
  assign dp = !(state == SHOW && digit == 2'd3 && page_q);
`else
  assign dp = 1'b1;
`endif

  assign segment = {dp, seg_q};

endmodule

// File: tb/tb_regfile_scan_display.sv
// Scoreboard bench: a timeline model predicts every cycle's outputs; a negedge monitor compares.
module tb_regfile_scan_display;
  localparam int D = 4;
  localparam int P = D + 2;
  localparam int F = 4 * P;

  typedef struct {
    logic [3:0] an;
    logic [7:0] seg;
    logic [2:0] addr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, page, blank;
  logic [3:0] rd_data;
  logic [2:0] rd_addr;
  logic [7:0] segment;
  logic [3:0] anode;

  logic [3:0] regs [8];
  logic [6:0] dec  [16];
  exp_t       exq [$];

  int  vectors = 0, errors = 0;
  int  t = 0;
  bit  pg = 0, started = 0;
  logic [6:0] hold = 7'h7F;

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  regfile_scan_display #(.DWELL_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .page(page), .blank(blank),
    .rd_data(rd_data), .rd_addr(rd_addr), .segment(segment), .anode(anode)
  );

  // Reference: position in the frame is t; digit = t/P, phase = t%P (0 settle, 1 capture, >=2 lit).
  always @(posedge clk) begin
    int p;
    logic [1:0] dg;
    exp_t e;
    if (reset) begin
      t = 0; pg = 0; hold = 7'h7F; started = 1;
    end else if (started) begin
      p  = t % P;
      dg = 2'((t / P) % 4);
      if (p == 1) hold = dec[regs[{pg, dg}]];
      t = t + 1;
      if (t == F) begin t = 0; pg = page; end
    end
    #2;
    if (started) begin
      p  = t % P;
      dg = 2'((t / P) % 4);
      e.an   = (p >= 2 && !blank) ? ~(4'b0001 << dg) : 4'hF;
      e.addr = {pg, dg};
`ifdef REGFILE_SCAN_PAGE_DP_EN
      e.seg  = {!(p >= 2 && dg == 2'd3 && pg), hold};
`else
      e.seg  = {1'b1, hold};
`endif
      exq.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (exq.size() > 0) begin
      e = exq.pop_front();
      vectors++;
      if (anode !== e.an) begin
        errors++;
        $display("FAIL anode t=%0d got %b exp %b", t, anode, e.an);
      end
      vectors++;
      if (segment !== e.seg) begin
        errors++;
        $display("FAIL segment t=%0d got %h exp %h", t, segment, e.seg);
      end
      vectors++;
      if (rd_addr !== e.addr) begin
        errors++;
        $display("FAIL rd_addr t=%0d got %0d exp %0d", t, rd_addr, e.addr);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_pos(input int pos);
    int i;
    for (i = 0; i < 2 * F && t != pos; i++) cyc(1);
    vectors++;
    if (t != pos) begin
      errors++;
      $display("FAIL wait_pos got %0d exp %0d", t, pos);
    end
  endtask

  initial begin
    dec = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    regs = '{4'h1, 4'hA, 4'h0, 4'hF, 4'h8, 4'h7, 4'h6, 4'h5};
    reset = 1'b1; page = 1'b0; blank = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(2 * F);
    // page toggles mid digit 1; the current frame must stay on the lower page
    wait_pos(P + 2);
    page = 1'b1;
    cyc(2 * F);
    blank = 1'b1;
    cyc(30);
    blank = 1'b0;
    cyc(30);
    // reset in the middle of digit 2's dwell
    wait_pos(2 * P + 3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(30);
    page = 1'b0;
    cyc(F);
    for (int i = 0; i < 2500; i++) begin
      reset = ($urandom % 300 == 0);
      if ($urandom % 50 == 0) page = ~page;
      blank = ($urandom % 8 == 0);
      if ($urandom % 3 == 0) regs[$urandom % 8] = 4'($urandom);
      cyc(1);
    end
    reset = 1'b0; blank = 1'b0;
    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
